// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch sequencer.
package fetch_pkg;
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DROP} fetch_state_e;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with redirect load (priority) and sequential increment.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  inc_i,
  input  logic [DATA_WIDTH-1:0] target_i,
  output logic [DATA_WIDTH-1:0] pc_o
);
  logic [DATA_WIDTH-1:0] pc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_q <= RESET_PC;
    else if (load_i) pc_q <= target_i;
    else if (inc_i) pc_q <= pc_q + DATA_WIDTH'(INSTR_BYTES);
  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer driving a req/gnt/rvalid memory port and a valid/ready output.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic [DATA_WIDTH-1:0] redirect_imm,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic [DATA_WIDTH-1:0] pc
);
  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_pc_q, target;
  logic                  capture;
  assign target  = redirect_pc + redirect_imm;
  assign capture = (state_q == WAIT) && imem_rvalid && !redirect;
  // Every state honours a redirect by loading the target; only the state transition differs.
  fetch_pc_reg #(.DATA_WIDTH(DATA_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load_i  (redirect),
    .inc_i   (capture),
    .target_i(target),
    .pc_o    (pc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= BOOT;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = REQ;
      REQ:     state_d = imem_gnt ? (redirect ? DROP : WAIT) : REQ;
      WAIT:    state_d = imem_rvalid ? (redirect ? REQ : HOLD) : (redirect ? DROP : WAIT);
      HOLD:    state_d = (redirect || instr_ready) ? REQ : HOLD;
      DROP:    state_d = imem_rvalid ? REQ : DROP;
      default: state_d = BOOT;
    endcase
  end
  always_comb begin
    imem_req    = state_q == REQ;
    instr_valid = state_q == HOLD;
    imem_addr   = pc;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else if (capture) begin
      instr_q    <= imem_rdata;
      instr_pc_q <= pc;
    end
  assign instr    = instr_q;
  assign instr_pc = instr_pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed-vector bench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;
  logic        clk = 0, rst = 1;
  logic        imem_req, imem_gnt = 0, imem_rvalid = 0, redirect = 0;
  logic        instr_valid, instr_ready = 0;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, redirect_imm = 0;
  logic [31:0] instr, instr_pc, pc;
  int          checks = 0, failures = 0;

  fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .redirect_imm(redirect_imm),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL reset_ctl req=%b valid=%b exp 0 0", imem_req, instr_valid); end
    checks++; if (pc !== 32'h0 || imem_addr !== 32'h0) begin failures++; $display("FAIL reset_pc pc=%h addr=%h exp 0", pc, imem_addr); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr instr=%h instr_pc=%h exp 0", instr, instr_pc); end
    rst = 0;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL boot_req got=%b exp=0", imem_req); end
    cyc();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req req=%b addr=%h exp 1 0", imem_req, imem_addr); end
  endtask

  task automatic test_zero_wait();
    for (int k = 0; k < 4; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || instr_valid !== 1'b0) begin failures++; $display("FAIL zw_req%0d req=%b addr=%h valid=%b exp 1 %h 0", k, imem_req, imem_addr, instr_valid, 32'(4 * k)); end
      imem_gnt = 1; cyc(); imem_gnt = 0;
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL zw_wait%0d req=%b valid=%b exp 0 0", k, imem_req, instr_valid); end
      imem_rvalid = 1; imem_rdata = word(32'(4 * k)); cyc(); imem_rvalid = 0;
      checks++; if (instr_valid !== 1'b1 || instr !== word(32'(4 * k)) || instr_pc !== 32'(4 * k)) begin failures++; $display("FAIL zw_hold%0d valid=%b instr=%h pc=%h exp 1 %h %h", k, instr_valid, instr, instr_pc, word(32'(4 * k)), 32'(4 * k)); end
      instr_ready = 1; cyc(); instr_ready = 0;
    end
  endtask

  task automatic test_slow_mem();
    for (int k = 0; k < 2; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL slow_hold_req%0d req=%b addr=%h exp 1 10", k, imem_req, imem_addr); end
      cyc();
    end
    imem_gnt = 1; cyc(); imem_gnt = 0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL slow_wait%0d req=%b valid=%b exp 0 0", k, imem_req, instr_valid); end
      cyc();
    end
    imem_rvalid = 1; imem_rdata = word(32'h10); cyc(); imem_rvalid = 0;
    checks++; if (instr_valid !== 1'b1 || instr !== word(32'h10) || instr_pc !== 32'h10) begin failures++; $display("FAIL slow_hold valid=%b instr=%h pc=%h exp 1 %h 10", instr_valid, instr, instr_pc, word(32'h10)); end
    instr_ready = 1; cyc(); instr_ready = 0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h14) begin failures++; $display("FAIL slow_next valid=%b req=%b addr=%h exp 0 1 14", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    redirect = 1; redirect_pc = 32'h10; redirect_imm = 32'h0; cyc(); redirect = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL rq_redirect req=%b addr=%h exp 1 10", imem_req, imem_addr); end
    imem_gnt = 1; cyc(); imem_gnt = 0;
    redirect = 1; redirect_pc = 32'h8; redirect_imm = 32'hFFFF_FFF8; cyc(); redirect = 0;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0) begin failures++; $display("FAIL wait_redirect req=%b valid=%b pc=%h exp 0 0 0", imem_req, instr_valid, pc); end
    cyc();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL drop_idle req=%b valid=%b exp 0 0", imem_req, instr_valid); end
    imem_rvalid = 1; imem_rdata = word(32'h10); cyc(); imem_rvalid = 0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL drop_done valid=%b req=%b addr=%h exp 0 1 0", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_gnt();
    imem_gnt = 1; redirect = 1; redirect_pc = 32'h100; redirect_imm = 32'h20; cyc(); imem_gnt = 0; redirect = 0;
    checks++; if (imem_req !== 1'b0 || pc !== 32'h120) begin failures++; $display("FAIL gnt_redirect req=%b pc=%h exp 0 120", imem_req, pc); end
    imem_rvalid = 1; imem_rdata = word(32'h0); cyc(); imem_rvalid = 0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h120) begin failures++; $display("FAIL gnt_refetch valid=%b req=%b addr=%h exp 0 1 120", instr_valid, imem_req, imem_addr); end
    imem_gnt = 1; cyc(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = word(32'h120); cyc(); imem_rvalid = 0;
    checks++; if (instr_valid !== 1'b1 || instr !== word(32'h120) || instr_pc !== 32'h120) begin failures++; $display("FAIL gnt_target valid=%b instr=%h pc=%h exp 1 %h 120", instr_valid, instr, instr_pc, word(32'h120)); end
  endtask

  task automatic test_hold_redirect();
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++; if (instr_valid !== 1'b1 || instr !== word(32'h120) || instr_pc !== 32'h120 || imem_req !== 1'b0) begin failures++; $display("FAIL hold_stall%0d valid=%b instr=%h pc=%h req=%b exp 1 %h 120 0", k, instr_valid, instr, instr_pc, imem_req, word(32'h120)); end
    end
    redirect = 1; instr_ready = 1; redirect_pc = 32'h200; redirect_imm = 32'h40; cyc(); redirect = 0; instr_ready = 0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h240) begin failures++; $display("FAIL hold_redirect valid=%b req=%b addr=%h exp 0 1 240", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_wait_redirect_rvalid();
    imem_gnt = 1; cyc(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = word(32'h240); redirect = 1; redirect_pc = 32'hFFFF_FFF0; redirect_imm = 32'hC; cyc();
    imem_rvalid = 0; redirect = 0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rv_redirect valid=%b req=%b addr=%h exp 0 1 fffffffc", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    imem_gnt = 1; cyc(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = word(32'hFFFF_FFFC); cyc(); imem_rvalid = 0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || pc !== 32'h0) begin failures++; $display("FAIL wrap_hold valid=%b instr_pc=%h pc=%h exp 1 fffffffc 0", instr_valid, instr_pc, pc); end
    instr_ready = 1; cyc(); instr_ready = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr req=%b addr=%h exp 1 0", imem_req, imem_addr); end
  endtask

  task automatic test_async_reset();
    imem_gnt = 1; redirect = 1; redirect_pc = 32'h300; redirect_imm = 32'h0; cyc(); imem_gnt = 0; redirect = 0;
    imem_rvalid = 1; imem_rdata = word(32'h0); cyc(); imem_rvalid = 0;
    imem_gnt = 1; cyc(); imem_gnt = 0;
    checks++; if (imem_req !== 1'b0 || pc !== 32'h300 || instr === 32'h0) begin failures++; $display("FAIL pre_reset req=%b pc=%h instr=%h exp 0 300 nonzero", imem_req, pc, instr); end
    #2 rst = 1;
    #1;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || imem_addr !== 32'h0) begin failures++; $display("FAIL async_ctl req=%b valid=%b pc=%h addr=%h exp 0 0 0 0", imem_req, instr_valid, pc, imem_addr); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL async_data instr=%h instr_pc=%h exp 0 0", instr, instr_pc); end
    cyc();
    rst = 0;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reboot_req got=%b exp=0", imem_req); end
    cyc();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL reboot_fetch req=%b addr=%h exp 1 0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_slow_mem();
    test_redirect_wait();
    test_redirect_gnt();
    test_hold_redirect();
    test_wait_redirect_rvalid();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives a request/grant/response instruction-memory port. It hands fetched words downstream with a valid/ready handshake, and applies branch redirects (PC-relative target = branch PC + immediate) at any point in a fetch. Any response already in flight is discarded on redirect. It sits between the decode stage and instruction memory, replacing a free-running PC register.

## Interface
- DATA_WIDTH, 32, width of PC, addresses, immediates and instruction words
- RESET_PC, 32'h0, PC value loaded on reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request, held until granted
- imem_addr  out  DATA_WIDTH  fetch address, equals current PC
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response word valid (exactly one per grant, ≥1 cycle after grant)
- imem_rdata  in  DATA_WIDTH  response word
- redirect  in  1  branch taken, single-cycle pulse
- redirect_pc  in  DATA_WIDTH  PC of the branching instruction
- redirect_imm  in  DATA_WIDTH  sign-extended branch offset
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr_ready  in  1  downstream accepts instruction
- instr  out  DATA_WIDTH  fetched instruction word
- instr_pc  out  DATA_WIDTH  address instr was fetched from
- pc  out  DATA_WIDTH  current PC (next address to fetch)

## Operation
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0. State is BOOT.
- Target = (redirect_pc + redirect_imm) mod 2^DATA_WIDTH. Sequential next = (pc + 4) mod 2^DATA_WIDTH. Both wrap silently, with no alignment check.
- States: BOOT, REQ, WAIT, HOLD, DROP.
- BOOT: imem_req=0. Goes to REQ on the next cycle. A redirect in BOOT loads the target and still goes to REQ.
- REQ: imem_req=1, imem_addr=pc.
  - gnt without redirect → WAIT.
  - Redirect without gnt → pc←target, stay REQ. The address changes before acceptance.
  - Redirect together with gnt → pc←target, go to DROP. The granted old-address response is discarded.
- WAIT: imem_req=0.
  - rvalid without redirect → instr←rdata, instr_pc←pc, instr_valid←1, pc←pc+4, go to HOLD.
  - Redirect without rvalid → pc←target, go to DROP.
  - Redirect together with rvalid → discard the word, pc←target, go to REQ.
- HOLD: instr_valid=1, and instr/instr_pc stay stable.
  - Redirect (takes priority over ready) → instr_valid←0, pc←target, go to REQ.
  - Otherwise instr_ready → instr_valid←0, go to REQ.
- DROP: waits for the orphan response.
  - rvalid → discard, go to REQ.
  - Redirect → pc←newest target, stay in DROP. If it coincides with rvalid, go to REQ with the new target.
- Never more than one outstanding request. instr_valid never rises while in DROP.
- Async reset mid-fetch returns everything to reset values immediately. The bench must not issue rvalid for a request granted before reset.

## Timing
- Reset release at edge 0 → BOOT. imem_req=1 from cycle 1.
- Zero-wait memory (gnt same cycle as req, rvalid one cycle later): instr_valid rises 2 cycles after req. With instr_ready tied high, the steady-state rate is 1 instruction per 3 cycles.
- Redirect sampled at edge N → imem_addr shows the target in cycle N+1 when in REQ/HOLD/BOOT or when rvalid coincides. Otherwise it shows in the cycle after the orphan rvalid.
- All outputs are registered or decoded from state/pc only. There is no combinational path from any input to any output.

## Structure
- Package fetch_pkg: state enum fetch_state_e {BOOT, REQ, WAIT, HOLD, DROP}, constant INSTR_BYTES=4.
- Sub-module fetch_pc_reg: PC register with async reset to RESET_PC, load (target) and increment (+INSTR_BYTES) controls, with load having priority. The FSM and output registers stay in fetch_ctrl.

## Test plan
- Reset, zero-wait memory, instr_ready=1: imem_addr sequence 0,4,8,C. instr_pc matches. instr_valid pulses every 3rd cycle.
- Memory with gnt 2 cycles late and rvalid 3 cycles after gnt: imem_req held until gnt, imem_addr stable, exactly one instruction per grant.
- In WAIT at pc=0x10, redirect_pc=0x8, imm=0xFFFF_FFF8: the orphan rvalid is discarded (instr_valid stays 0) and the next imem_addr is 0x0.
- redirect coincident with imem_gnt in REQ: DROP entered, next request is at target, the first instr_valid carries target's word.
- HOLD with instr_ready=0 for 5 cycles, then redirect and ready together: instruction dropped, instr_valid=0, next fetch at target.
- pc=0xFFFF_FFFC sequential fetch: next imem_addr=0x0. Async rst asserted in WAIT: all outputs at reset values before the next clock edge.
